// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite word memory responder with independent read/write FSMs and
// programmable wait-state latency on each channel.
//
// state  | meaning
// R_IDLE | ARREADY high, waiting for a read address
// R_WAIT | read latency countdown
// R_RESP | RVALID high, holding RDATA/RRESP until RREADY
// W_IDLE | collecting AW and W in any order
// W_WAIT | write latency countdown, commit on exit
// W_RESP | BVALID high, holding BRESP until BREADY
module axi_lite_slave_mem #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DEPTH         = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                    READ_LATENCY  = 2,
    parameter int                    WRITE_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDXW  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH * BYTES);
    localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
    localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

    // An address below BASE_ADDR wraps to a huge offset, so one compare covers both bounds.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] d;
        d = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a[OFF-1:0] != '0) || (d >= SPAN);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    r_state_e              r_state_q, r_state_d;
    logic [3:0]            r_cnt_q, r_cnt_d;
    logic                  ar_ready_q, ar_ready_d;
    logic                  r_valid_q, r_valid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    w_state_e              w_state_q, w_state_d;
    logic [3:0]            w_cnt_q, w_cnt_d;
    logic                  aw_ready_q, aw_ready_d;
    logic                  w_ready_q, w_ready_d;
    logic                  b_valid_q, b_valid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BYTES-1:0]      wstrb_q, wstrb_d;

    logic                  ar_hs, rd_sample, rd_err;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [IDXW-1:0]       rd_idx;

    logic                  aw_hs, w_hs, wr_capture, wr_commit, wr_err, mem_we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BYTES-1:0]      wr_strb;
    logic [IDXW-1:0]       wr_idx;

    // A low READY means the channel value is already latched; otherwise take it live.
    assign ar_hs   = (r_state_q == R_IDLE) && ARVALID && ar_ready_q;
    assign rd_addr = ar_ready_q ? ARADDR : araddr_q;
    assign rd_idx  = IDXW'((rd_addr - BASE_ADDR) >> OFF);
    assign rd_err  = addr_err(rd_addr);

    assign aw_hs      = (w_state_q == W_IDLE) && AWVALID && aw_ready_q;
    assign w_hs       = (w_state_q == W_IDLE) && WVALID && w_ready_q;
    assign wr_capture = (w_state_q == W_IDLE) && (aw_hs || !aw_ready_q) && (w_hs || !w_ready_q);
    assign wr_commit  = ((w_state_q == W_WAIT) && (w_cnt_q <= 4'd1))
                        || ((WRITE_LATENCY == 0) && wr_capture);
    assign wr_addr    = aw_ready_q ? AWADDR : awaddr_q;
    assign wr_data    = w_ready_q ? WDATA : wdata_q;
    assign wr_strb    = w_ready_q ? WSTRB : wstrb_q;
    assign wr_idx     = IDXW'((wr_addr - BASE_ADDR) >> OFF);
    assign wr_err     = addr_err(wr_addr);
    assign mem_we     = wr_commit && !wr_err && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q  <= R_IDLE;
            r_cnt_q    <= '0;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            araddr_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            w_state_q  <= W_IDLE;
            w_cnt_q    <= '0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            b_valid_q  <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            r_state_q  <= r_state_d;
            r_cnt_q    <= r_cnt_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            araddr_q   <= araddr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            w_state_q  <= w_state_d;
            w_cnt_q    <= w_cnt_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            bresp_q    <= bresp_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

    // Memory is not reset; a read sampling this edge sees the pre-write word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_strb[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = (READ_LATENCY == 0) ? R_RESP : R_WAIT;
            R_WAIT:  if (r_cnt_q <= 4'd1) r_state_d = R_RESP;
            R_RESP:  if (RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_cnt_d    = r_cnt_q;
        araddr_d   = araddr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_sample  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ar_ready_d = 1'b0;
                    araddr_d   = ARADDR;
                    r_cnt_d    = RD_LAT;
                    rd_sample  = (READ_LATENCY == 0);
                end
            end
            R_WAIT: begin
                if (r_cnt_q <= 4'd1) rd_sample = 1'b1;
                else                 r_cnt_d   = r_cnt_q - 4'd1;
            end
            R_RESP: begin
                if (RREADY) begin
                    r_valid_d  = 1'b0;
                    ar_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (rd_sample) begin
            r_valid_d = 1'b1;
            rdata_d   = rd_err ? '0 : mem_q[rd_idx];
            rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (wr_capture) w_state_d = (WRITE_LATENCY == 0) ? W_RESP : W_WAIT;
            W_WAIT:  if (w_cnt_q <= 4'd1) w_state_d = W_RESP;
            W_RESP:  if (BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        bresp_d    = bresp_q;
        w_cnt_d    = w_cnt_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_ready_d = 1'b0;
                    awaddr_d   = AWADDR;
                end
                if (w_hs) begin
                    w_ready_d = 1'b0;
                    wdata_d   = WDATA;
                    wstrb_d   = WSTRB;
                end
                if (wr_capture) w_cnt_d = WR_LAT;
            end
            W_WAIT: begin
                if (w_cnt_q > 4'd1) w_cnt_d = w_cnt_q - 4'd1;
            end
            W_RESP: begin
                if (BREADY) begin
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                    w_ready_d  = 1'b1;
                end
            end
            default: ;
        endcase
        if (wr_commit) begin
            b_valid_d = 1'b1;
            bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    assign ARREADY = ar_ready_q;
    assign RVALID  = r_valid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign AWREADY = aw_ready_q;
    assign WREADY  = w_ready_q;
    assign BVALID  = b_valid_q;
    assign BRESP   = bresp_q;

endmodule

// File: doc/axi_lite_slave_mem.md
Name: axi_lite_slave_mem

Overview:
- AXI4-Lite responder: a word-organised on-chip memory that answers single-beat read and write transactions from the team's DMA controller and other AXI-Lite initiators.
- Read and write channels are served by independent state machines, with programmable wait-state latency to exercise initiator handshakes.
- Decodes byte addresses, applies byte strobes and flags bad accesses with SLVERR.
- Sits on the memory side of the DMA bus as the source and destination target.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH, 64, number of DATA_WIDTH words in the memory; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*DATA_WIDTH/8.
- READ_LATENCY, 2, wait cycles between AR handshake and RVALID assertion (0..15).
- WRITE_LATENCY, 1, wait cycles between capture of both AW and W and the memory commit (0..15).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ARADDR  in  ADDR_WIDTH  read byte address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- AWADDR  in  ADDR_WIDTH  write byte address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte-lane write enables.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.

Behaviour:
- Reset (async, active-high):
  - ARREADY=1, AWREADY=1, WREADY=1.
  - RVALID=0, BVALID=0, RDATA=0, RRESP=0, BRESP=0.
  - Both FSMs go to IDLE; wait counters cleared.
  - Memory array is not reset; contents are preserved across reset.
  - Reset mid-transaction drops the transaction silently. A write not yet committed does not modify memory.
- Address decode:
  - idx = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
  - Error if addr[log2(DATA_WIDTH/8)-1:0] != 0, or addr < BASE_ADDR, or addr >= BASE_ADDR + DEPTH*DATA_WIDTH/8.
  - Error result: RRESP/BRESP = SLVERR, RDATA = 0, no memory write.
- Read FSM (R_IDLE, R_WAIT, R_RESP):
  - R_IDLE: ARREADY=1. On ARVALID&&ARREADY at edge N: latch ARADDR, ARREADY<=0, load counter with READ_LATENCY.
    - Next state is R_WAIT, or R_RESP directly if READ_LATENCY=0.
  - R_WAIT: counter decrements each cycle. At 1, go to R_RESP.
  - RVALID first high in cycle N+1+READ_LATENCY. RDATA/RRESP are sampled from memory at the edge entering R_RESP.
  - R_RESP: RVALID=1 and RDATA/RRESP are held stable until RREADY. On RVALID&&RREADY: RVALID<=0, ARREADY<=1, back to R_IDLE.
  - RDATA retains its last value after the handshake.
- Write FSM (W_IDLE, W_WAIT, W_RESP):
  - W_IDLE: AWREADY and WREADY are independent.
    - AW handshake latches the address and drops AWREADY.
    - W handshake latches WDATA/WSTRB and drops WREADY.
    - AW and W may arrive in either order or in the same cycle.
  - On the edge where both are captured, load counter with WRITE_LATENCY and go to W_WAIT.
  - Commit edge: the edge leaving W_WAIT, or the capture edge itself if WRITE_LATENCY=0.
    - Each byte lane i with WSTRB[i]=1 is written to mem[idx].
    - BVALID<=1 and BRESP is set; go to W_RESP.
  - W_RESP: BVALID=1 and BRESP held until BREADY. On BVALID&&BREADY: BVALID<=0, AWREADY<=1, WREADY<=1, back to W_IDLE.
- Only one outstanding transaction per channel; no bursts, no IDs.
- Read/write collision:
  - Read and write FSMs run concurrently.
  - If the read-sample edge coincides with the write-commit edge to the same idx, RDATA returns the old (pre-write) data.
  - Any later read returns the new data.
- Error writes still complete the full handshake, with BRESP=SLVERR.
- VALID outputs never depend combinationally on READY inputs; all outputs are registered.

Test Plan:
- Write then read, default params:
  - AW 0x10, WDATA 0xDEADBEEF, WSTRB 4'hF, BREADY=1 -> BVALID 2 cycles after capture, BRESP=00.
  - AR 0x10 -> RVALID 3 cycles after AR handshake, RDATA 0xDEADBEEF, RRESP=00.
- Byte strobes: mem[0]=0x11223344; write 0xAABBCCDD with WSTRB 4'b0101 -> read 0x11BB33DD.
- AW/W ordering: WVALID 3 cycles before AWVALID (addr 0x20, data 0x5A5A5A5A) -> WREADY drops after W capture, commit waits for AW, read returns 0x5A5A5A5A.
  - Repeat with AW and W in the same cycle: same result.
- Backpressure and errors:
  - RREADY held low 5 cycles -> RVALID and RDATA held stable throughout.
  - AR 0x102 (misaligned) -> RRESP=10, RDATA=0.
  - AW 0x100 with DEPTH=64 (out of range) -> BRESP=10, no memory change.
- Collision, READ_LATENCY=0 and WRITE_LATENCY=0: read-sample and write-commit edges coincide on addr 0x8 (old 0x1, new 0x2) -> RDATA=0x1; a second read returns 0x2.
- Reset mid-write: assert reset in W_WAIT -> BVALID=0, AWREADY/WREADY=1, target word unchanged; previously written words still readable.
